// File: rtl/sopc_nios2_mult_pkg.sv
// Shared types and constants for the sequential NIOS II mulx unit.
package sopc_nios2_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int unsigned PART_W_DEF = 16;

endpackage

// File: rtl/sopc_nios2_mult_part.sv
// Unsigned PART_W x PART_W combinational multiplier; the single product
// stage that the sequencer reuses for every slice pair.
module sopc_nios2_mult_part
    import sopc_nios2_mult_pkg::*;
#(
    parameter int unsigned PART_W = PART_W_DEF
) (
    input  logic [PART_W-1:0]   a,
    input  logic [PART_W-1:0]   b,
    output logic [2*PART_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/sopc_nios2_0_mulx_seq.sv
// Sequential WIDTH x WIDTH multiplier built from one PART_W slice multiplier.
// Optional macro SOPC_MULX_ZERO_SKIP_EN: zero operands bypass accumulation.
module sopc_nios2_0_mulx_seq
    import sopc_nios2_mult_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned PART_W = PART_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sign1,
    input  logic             sign2,
    input  logic             hi_sel,
    output logic             ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned N  = WIDTH / PART_W;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              neg_q;
    logic              hi_q;
    logic [AW-1:0]     acc;
    logic [CW-1:0]     i_cnt;
    logic [CW-1:0]     j_cnt;
    logic              last_step;
    logic              zero_op;
    logic              neg1;
    logic              neg2;
    logic [PART_W-1:0] a_slice;
    logic [PART_W-1:0] b_slice;
    logic [2*PART_W-1:0] pp;
    logic [AW-1:0]     term;
    logic [AW-1:0]     fix_sum;

    assign ready     = (state == IDLE);
    assign last_step = (i_cnt == CW'(N - 1)) && (j_cnt == CW'(N - 1));
    assign neg1      = sign1 & src1[WIDTH-1];
    assign neg2      = sign2 & src2[WIDTH-1];

`ifdef SOPC_MULX_ZERO_SKIP_EN
    assign zero_op = (src1 == '0) || (src2 == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Slice i of a against slice j of b, placed at its weight in the 2W sum.
    assign a_slice = PART_W'(a_mag >> (32'(i_cnt) * PART_W));
    assign b_slice = PART_W'(b_mag >> (32'(j_cnt) * PART_W));
    assign term    = AW'(pp) << ((32'(i_cnt) + 32'(j_cnt)) * PART_W);
    assign fix_sum = neg_q ? -acc : acc;

    sopc_nios2_mult_part #(
        .PART_W (PART_W)
    ) u_part (
        .a (a_slice),
        .b (b_slice),
        .p (pp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zero_op ? FIX : ACC;
                end
            end
            ACC: begin
                if (last_step) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_mag        <= '0;
            b_mag        <= '0;
            neg_q        <= 1'b0;
            hi_q         <= 1'b0;
            acc          <= '0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Negating the most-negative value yields 2^(W-1) as unsigned.
                        a_mag <= neg1 ? -src1 : src1;
                        b_mag <= neg2 ? -src2 : src2;
                        neg_q <= neg1 ^ neg2;
                        hi_q  <= hi_sel;
                        acc   <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                ACC: begin
                    acc <= acc + term;
                    if (i_cnt == CW'(N - 1)) begin
                        i_cnt <= '0;
                        j_cnt <= j_cnt + 1'b1;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                FIX: begin
                    result       <= hi_q ? fix_sum[AW-1:WIDTH] : fix_sum[WIDTH-1:0];
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sopc_nios2_0_mulx_seq.md
SOPC_NIOS2_0_MULX_SEQ -- requirements
Module: sopc_nios2_0_mulx_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are 16, 32, 48 and 64.
REQ-002 SHALL have parameter PART_W, default 16, partial-product slice width; WIDTH SHALL be a multiple of PART_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request; sampled only while ready=1.
REQ-006 SHALL have ports src1 and src2, input, WIDTH each, operands sampled with start.
REQ-007 SHALL have ports sign1 and sign2, input, 1 each, 1 = treat that operand as two's complement; sampled with start.
REQ-008 SHALL have port hi_sel, input, 1, 1 = return product bits [2W-1:W], 0 = return bits [W-1:0]; sampled with start.
REQ-009 SHALL have port ready, output, 1, high in IDLE only.
REQ-010 SHALL have port result_valid, output, 1, one-cycle pulse marking a new result.
REQ-011 SHALL have port result, output, WIDTH, the selected product half; held until the next result_valid.

Function
REQ-012 SHALL implement FSM IDLE -> ACC -> FIX -> IDLE; start&ready moves IDLE->ACC.
REQ-013 On accepted start, SHALL latch |src1|, |src2| (magnitude only when the sign bit is set and the operand is signed), neg = s1^s2, hi_sel, and clear the 2W-bit accumulator.
REQ-014 ACC SHALL last exactly N*N cycles, N=WIDTH/PART_W; cycle k adds slice(i)*slice(j), shifted left by (i+j)*PART_W, with i = k mod N and j = k div N.
REQ-015 FIX SHALL take one cycle: two's-complement negate the 2W-bit sum if neg, then select the half.
REQ-016 result and result_valid SHALL register at the FIX->IDLE edge; result_valid SHALL be high in the cycle after that edge.
REQ-017 Latency from the start-sample edge to result_valid high SHALL be N*N+2 cycles (6 for WIDTH=32).
REQ-018 start while ready=0 SHALL be ignored, with no queuing.
REQ-019 start in the cycle where result_valid=1 SHALL be accepted (back-to-back operation).
REQ-020 Magnitude of the most-negative value (e.g. 0x80000000) SHALL be taken as unsigned 2^(W-1), with no overflow; the accumulator is 2W bits wide and never wraps.
REQ-021 Mixed mode (sign1=1, sign2=0) SHALL give the exact mathematical product truncated to 2W bits.

Reset
REQ-022 reset_n low SHALL force IDLE, ready=1, result_valid=0, result=0, and clear the accumulator and latched operands, asynchronously.
REQ-023 Reset mid-operation SHALL abandon the product; no result_valid SHALL follow release.

Configuration
REQ-024 With macro SOPC_MULX_ZERO_SKIP_EN defined, an accepted start with src1==0 or src2==0 SHALL go IDLE->FIX directly, giving result 0 with latency 2.
REQ-025 Without SOPC_MULX_ZERO_SKIP_EN, zero operands SHALL take the full N*N+2 latency; the result SHALL be identical either way.

Structure
REQ-026 Package sopc_nios2_mult_pkg SHALL hold the FSM state typedef (IDLE/ACC/FIX) and constant PART_W_DEF=16.
REQ-027 Sub-module sopc_nios2_mult_part SHALL be a combinational unsigned PART_W x PART_W multiplier, instantiated once and mapped to a dedicated multiplier.
REQ-028 Slice muxing, shifting, accumulation and the FSM SHALL reside in the top module.

Verification
REQ-029 WIDTH=32, unsigned, 0xFFFFFFFF*0xFFFFFFFF: hi_sel=0 -> 0x00000001; hi_sel=1 -> 0xFFFFFFFE; result_valid 6 cycles after start.
REQ-030 Signed -2*3: lo -> 0xFFFFFFFA, hi -> 0xFFFFFFFF; signed 0x80000000*0x80000000 hi -> 0x40000000.
REQ-031 Mixed sign1=1, sign2=0, 0xFFFFFFFF*0xFFFFFFFF: hi -> 0xFFFFFFFF, lo -> 0x00000001.
REQ-032 start pulsed on cycles 0, 2 and 6: only the cycle-0 and cycle-6 starts are accepted, with results at cycles 6 and 12.
REQ-033 reset_n low at cycle 3 of an operation -> result=0, ready=1, no result_valid after release.
REQ-034 SOPC_MULX_ZERO_SKIP_EN defined, 0*0x1234 -> result 0, result_valid 2 cycles after start; without the macro, 6 cycles.
